// File: rtl/alu32_nibble_sequencer.sv
// alu32_nibble_sequencer: runs a wide ALU operation one nibble per cycle through a shared 4-bit ALU slice
module alu32_nibble_sequencer #(
    parameter  int NIBBLES = 8,
    localparam int W       = 4 * NIBBLES,
    localparam int IW      = NIBBLES > 1 ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [1:0]   op_sel,
    input  logic         cin,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [1:0]   alu_s,
    output logic         alu_cin,
    input  logic [3:0]   alu_y,
    input  logic         alu_cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [W-1:0] a_q, b_q;
    logic [1:0] s_q;
    logic cin_q, carry, last, run;
    logic [IW-1:0] idx;
    assign last  = idx == IW'(NIBBLES - 1);
    assign run   = state == RUN;
    assign ready = state == IDLE;
    assign done  = state == DONE;
    assign zero  = result == '0;
    // slice inputs are only driven while a nibble is being processed
    always_comb begin
        alu_a   = run ? a_q[4*idx +: 4] : 4'h0;
        alu_b   = run ? b_q[4*idx +: 4] : 4'h0;
        alu_s   = run ? s_q : 2'b00;
        alu_cin = run && (idx == '0 ? cin_q : carry);
    end
    // next state: accept from IDLE, leave RUN after the top nibble, DONE lasts one cycle
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN)  : IDLE;
    end
    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    // operand latch, nibble index, carry chain and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= 2'b00;
            cin_q  <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_q    <= op_a;
            b_q    <= op_b;
            s_q    <= op_sel;
            cin_q  <= cin;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
        end else if (run) begin
            result[4*idx +: 4] <= alu_y;
            carry <= alu_cout;
            if (last) cout <= alu_cout;
            else idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu32_nibble_sequencer.sv
// tb_alu32_nibble_sequencer: directed checks of the nibble sequencer against a behavioural 4-bit ALU slice
module tb_alu32_nibble_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, cin = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, result;
    logic [1:0] op_sel = 2'b00, alu_s;
    logic ready, done, cout, zero, alu_cin, alu_cout;
    logic [3:0] alu_a, alu_b, alu_y;
    logic start1 = 1'b0, cin1 = 1'b0;
    logic [3:0] op_a1 = '0, op_b1 = '0, result1;
    logic [1:0] op_sel1 = 2'b00, alu_s1;
    logic ready1, done1, cout1, zero1, alu_cin1, alu_cout1;
    logic [3:0] alu_a1, alu_b1, alu_y1;
    int vectors = 0, miscompares = 0;
    logic [7:0] cins;
    int n;

    always #5 clk = ~clk;

    alu32_nibble_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .cin(cin),
        .ready(ready), .done(done), .result(result), .cout(cout), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin), .alu_y(alu_y), .alu_cout(alu_cout)
    );

    alu32_nibble_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1), .op_sel(op_sel1), .cin(cin1),
        .ready(ready1), .done(done1), .result(result1), .cout(cout1), .zero(zero1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_cin(alu_cin1), .alu_y(alu_y1), .alu_cout(alu_cout1)
    );

    // behavioural ALU_4BIT slices: 11 adds with carry, 00 ANDs, others give zero
    always_comb begin
        {alu_cout, alu_y} = alu_s == 2'b11 ? 5'(alu_a) + 5'(alu_b) + 5'(alu_cin) :
                            alu_s == 2'b00 ? {1'b0, alu_a & alu_b} : 5'h0;
        {alu_cout1, alu_y1} = alu_s1 == 2'b11 ? 5'(alu_a1) + 5'(alu_b1) + 5'(alu_cin1) :
                              alu_s1 == 2'b00 ? {1'b0, alu_a1 & alu_b1} : 5'h0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                         input logic c, input logic [31:0] er, input logic ec, output logic [7:0] cv);
        int bad = 0;
        op_a = a; op_b = b; op_sel = s; cin = c; start = 1'b1;
        chk({tag, " ready before accept"}, 32'(ready), 32'd1);
        tick;
        start = 1'b0;
        op_a = ~a; op_b = ~b; op_sel = ~s; cin = ~c;
        for (int i = 0; i < 8; i++) begin
            cv[i] = alu_cin;
            if (alu_s !== s || alu_a !== a[4*i +: 4] || alu_b !== b[4*i +: 4] || done || ready) bad++;
            tick;
        end
        chk({tag, " run-phase errors"}, 32'(bad), 32'd0);
        chk({tag, " done after 8 nibbles"}, 32'(done), 32'd1);
        chk({tag, " result"}, result, er);
        chk({tag, " cout"}, 32'(cout), 32'(ec));
        chk({tag, " zero"}, 32'(zero), 32'(er == 32'h0));
        tick;
        chk({tag, " done single cycle"}, 32'(done), 32'd0);
        chk({tag, " ready after done"}, 32'(ready), 32'd1);
        chk({tag, " result held"}, result, er);
    endtask

    initial begin
        tick; tick;
        rst = 1'b0;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'h0);
        chk("reset zero", 32'(zero), 32'd1);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'h0);

        op_a = 32'h12345678; op_b = 32'h11111111; op_sel = 2'b11; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        chk("midrun busy", 32'(ready), 32'd0);
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'h0);
        chk("abort zero", 32'(zero), 32'd1);
        chk("abort cout", 32'(cout), 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n++;
            tick;
        end
        chk("abort no done", 32'(n), 32'd0);

        do_op("ripple", 32'hFFFFFFFF, 32'h00000001, 2'b11, 1'b0, 32'h00000000, 1'b1, cins);
        chk("ripple alu_cin", 32'(cins), 32'hFE);
        do_op("addcin", 32'h12345678, 32'h11111111, 2'b11, 1'b1, 32'h2345678A, 1'b0, cins);
        chk("addcin alu_cin", 32'(cins), 32'h01);
        do_op("and", 32'hF0F0A5A5, 32'hFF00FFFF, 2'b00, 1'b0, 32'hF000A5A5, 1'b0, cins);
        chk("and alu_cin", 32'(cins), 32'h00);

        op_a = 32'h00000001; op_b = 32'h00000002; op_sel = 2'b11; cin = 1'b0; start = 1'b1;
        tick;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            op_a = $urandom; op_b = $urandom; op_sel = 2'($urandom); cin = 1'($urandom);
            if (ready || done) n++;
            tick;
        end
        chk("hs start ignored in run", 32'(n), 32'd0);
        chk("hs done", 32'(done), 32'd1);
        chk("hs first result", result, 32'h00000003);
        chk("hs not ready in done", 32'(ready), 32'd0);
        op_a = 32'h00000010; op_b = 32'h00000020; op_sel = 2'b11; cin = 1'b0;
        tick;
        chk("hs ready after done", 32'(ready), 32'd1);
        tick;
        chk("hs second accept", 32'(ready), 32'd0);
        start = 1'b0;
        op_a = 32'hDEADBEEF; op_b = 32'h12345678;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n++;
            tick;
        end
        chk("hs second no early done", 32'(n), 32'd0);
        chk("hs second done", 32'(done), 32'd1);
        chk("hs second result", result, 32'h00000030);
        tick;

        op_a1 = 4'h9; op_b1 = 4'h8; op_sel1 = 2'b11; cin1 = 1'b0; start1 = 1'b1;
        chk("n1 ready", 32'(ready1), 32'd1);
        tick;
        start1 = 1'b0;
        chk("n1 run not done", 32'(done1), 32'd0);
        chk("n1 run busy", 32'(ready1), 32'd0);
        tick;
        chk("n1 done", 32'(done1), 32'd1);
        chk("n1 result", 32'(result1), 32'h1);
        chk("n1 cout", 32'(cout1), 32'd1);
        chk("n1 zero", 32'(zero1), 32'd0);
        tick;
        chk("n1 done cleared", 32'(done1), 32'd0);
        chk("n1 ready back", 32'(ready1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
